// File: rtl/run_length_monitor.sv
// -----------------------------------------------------------------------------
// run_length_monitor
//
// Measures the length, in enabled clock cycles, of every run of consecutive 1s
// on a monitored bit. The bit is normally the output of the upstream sequence
// FSM. Each completed length is placed in a one-deep registered output slot
// that uses a valid/ready handshake.
//
// Lengths that reach the counter ceiling (2^W-1) are reported as that ceiling,
// with len_sat set. A completed run that finds the slot occupied is dropped,
// and the sticky overrun flag is raised.
//
// Parameters
//   W           counter / len width; the largest reportable length is 2^W-1
//
// Ports
//   clk         system clock, rising edge active
//   rst         asynchronous active-low reset (release synchronous to clk)
//   din         monitored bit, sampled when en=1
//   en          sample enable; when low, run state and counter hold
//   len         length of the last completed run
//   len_valid   len/len_sat hold an unconsumed result
//   len_ready   consumer accepts the result on an edge where len_valid=1
//   len_sat     reported run reached 2^W-1 (true length >= 2^W-1)
//   run_active  a run is currently being counted
//   overrun     sticky: a completed run was dropped because the slot was full
// -----------------------------------------------------------------------------
module run_length_monitor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din,
  input  logic         en,
  output logic [W-1:0] len,
  output logic         len_valid,
  input  logic         len_ready,
  output logic         len_sat,
  output logic         run_active,
  output logic         overrun
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [W-1:0] CNT_MAX = '1;

  // Run tracking
  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_cnt;
  logic [W-1:0]   w_cnt_nxt;
  logic           w_emit;

  // Output slot
  logic [W-1:0]   r_len;
  logic           r_len_valid;
  logic           r_len_sat;
  logic           r_overrun;
  logic           w_slot_free;
  logic           w_accept;

  // ---------------------------------------------------------------------------
  // Next-state / counter logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned. A missing default would infer a
  // latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (en && din) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = W'(1);
        end
      end

      S_RUN: begin
        if (en) begin
          if (din) begin
            // Saturate at the ceiling. Wrapping would report a short run.
            if (r_cnt != CNT_MAX) begin
              w_cnt_nxt = r_cnt + W'(1);
            end
          end else begin
            w_state_nxt = S_IDLE;
            w_emit      = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update from pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // One-deep output slot
  // ---------------------------------------------------------------------------
  // The slot counts as free when it is empty, or when its current content is
  // consumed on this same edge. An emit that coincides with a handshake
  // therefore replaces the result and does not count as an overrun.
  assign w_accept    = r_len_valid && len_ready;
  assign w_slot_free = !r_len_valid || len_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len       <= '0;
      r_len_valid <= 1'b0;
      r_len_sat   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_emit) begin
        if (w_slot_free) begin
          r_len       <= r_cnt;
          r_len_sat   <= (r_cnt == CNT_MAX);
          r_len_valid <= 1'b1;
        end else begin
          r_overrun   <= 1'b1;
        end
      end else if (w_accept) begin
        // len/len_sat keep their last values after consumption.
        r_len_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all taken directly from flops
  // ---------------------------------------------------------------------------
  assign len        = r_len;
  assign len_valid  = r_len_valid;
  assign len_sat    = r_len_sat;
  assign overrun    = r_overrun;
  assign run_active = (r_state == S_RUN);

endmodule

// File: tb/tb_run_length_monitor.sv
// -----------------------------------------------------------------------------
// tb_run_length_monitor
//
// Drives a W=8 and a W=4 instance of run_length_monitor from the same inputs.
// Expected values come from hand-derived vector tables, from hand-written
// corner-case sequences, and from a behavioural model. The model measures
// each run as an unbounded integer and clips the result to the ceiling.
// -----------------------------------------------------------------------------
module tb_run_length_monitor;

  logic       clk;
  logic       rst;
  logic       din;
  logic       en;
  logic       len_ready;

  logic [7:0] len8;
  logic       len_valid8, len_sat8, run_active8, overrun8;
  logic [3:0] len4;
  logic       len_valid4, len_sat4, run_active4, overrun4;

  int n_checks = 0;
  int n_errors = 0;

  run_length_monitor #(.W(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .en         (en),
    .len        (len8),
    .len_valid  (len_valid8),
    .len_ready  (len_ready),
    .len_sat    (len_sat8),
    .run_active (run_active8),
    .overrun    (overrun8)
  );

  run_length_monitor #(.W(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .en         (en),
    .len        (len4),
    .len_valid  (len_valid4),
    .len_ready  (len_ready),
    .len_sat    (len_sat4),
    .run_active (run_active4),
    .overrun    (overrun4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit in_run;
    int run_len;   // unbounded true length of the current run
    int len;
    bit valid;
    bit sat;
    bit ovr;
  } model_t;

  model_t m8, m4;

  function automatic model_t model_reset();
    model_t m;
    m.in_run  = 1'b0;
    m.run_len = 0;
    m.len     = 0;
    m.valid   = 1'b0;
    m.sat     = 1'b0;
    m.ovr     = 1'b0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, bit s_en, bit s_din,
                                        bit s_rdy, int maxv);
    model_t n;
    bit     emit;
    int     res;
    n    = m;
    emit = 1'b0;
    res  = 0;
    if (s_en) begin
      if (s_din) begin
        n.run_len = m.in_run ? m.run_len + 1 : 1;
        n.in_run  = 1'b1;
      end else if (m.in_run) begin
        emit     = 1'b1;
        res      = m.run_len;
        n.in_run = 1'b0;
      end
    end
    if (emit) begin
      if (!m.valid || s_rdy) begin
        n.len   = (res < maxv) ? res : maxv;
        n.sat   = (res >= maxv);
        n.valid = 1'b1;
      end else begin
        n.ovr = 1'b1;
      end
    end else if (m.valid && s_rdy) begin
      n.valid = 1'b0;
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advances the models with the inputs present at the edge, then samples
  // the outputs 1 time unit after the edge.
  task automatic tick();
    m8 = model_step(m8, en, din, len_ready, 255);
    m4 = model_step(m4, en, din, len_ready, 15);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit d, input int cycles);
    din = d;
    for (int k = 0; k < cycles; k++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m8  = model_reset();
    m4  = model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_both(input string tag, input int e_len, input bit e_valid,
                            input bit e_sat, input bit e_act, input bit e_ovr);
    check({tag, "_len8"},   32'(len8),        32'(e_len));
    check({tag, "_valid8"}, 32'(len_valid8),  32'(e_valid));
    check({tag, "_sat8"},   32'(len_sat8),    32'(e_sat));
    check({tag, "_act8"},   32'(run_active8), 32'(e_act));
    check({tag, "_ovr8"},   32'(overrun8),    32'(e_ovr));
    check({tag, "_len4"},   32'(len4),        32'(e_len));
    check({tag, "_valid4"}, 32'(len_valid4),  32'(e_valid));
    check({tag, "_sat4"},   32'(len_sat4),    32'(e_sat));
    check({tag, "_act4"},   32'(run_active4), 32'(e_act));
    check({tag, "_ovr4"},   32'(overrun4),    32'(e_ovr));
  endtask

  task automatic check_model(input string tag);
    check({tag, "_len8"},   32'(len8),        32'(m8.len));
    check({tag, "_valid8"}, 32'(len_valid8),  32'(m8.valid));
    check({tag, "_sat8"},   32'(len_sat8),    32'(m8.sat));
    check({tag, "_act8"},   32'(run_active8), 32'(m8.in_run));
    check({tag, "_ovr8"},   32'(overrun8),    32'(m8.ovr));
    check({tag, "_len4"},   32'(len4),        32'(m4.len));
    check({tag, "_valid4"}, 32'(len_valid4),  32'(m4.valid));
    check({tag, "_sat4"},   32'(len_sat4),    32'(m4.sat));
    check({tag, "_act4"},   32'(run_active4), 32'(m4.in_run));
    check({tag, "_ovr4"},   32'(overrun4),    32'(m4.ovr));
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: inputs for one edge plus outputs expected after that edge
  // ---------------------------------------------------------------------------
  typedef struct {
    bit din;
    bit en;
    bit rdy;
    int len;
    bit valid;
    bit sat;
    bit act;
    bit ovr;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  initial begin
    //           din   en    rdy  len valid sat  act  ovr
    // basic run 0,1,1,1,0
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    // enable gating: five 1s, en low on the 2nd and 3rd
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    // din=1 with en=0 in IDLE does not start a run
    vecs[13] = '{1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    // minimum run: a single sampled 1
    vecs[14] = '{1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0};
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst       = 1'b0;
    din       = 1'b0;
    en        = 1'b1;
    len_ready = 1'b1;
    m8        = model_reset();
    m4        = model_reset();
    #2;
    check_both("reset_init", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // --- table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      din       = vecs[i].din;
      en        = vecs[i].en;
      len_ready = vecs[i].rdy;
      tick();
      check_both($sformatf("vec%0d", i), vecs[i].len, vecs[i].valid,
                 vecs[i].sat, vecs[i].act, vecs[i].ovr);
    end
    // finish the single-1 run from the last row: len=1
    en = 1'b1;
    drive(1'b0, 1);
    check_both("min_run", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    len_ready = 1'b1;
    tick();

    // --- saturation: twenty 1s then 0; W=4 clips at 15, W=8 counts 20
    do_reset();
    en = 1'b1; len_ready = 1'b1;
    drive(1'b1, 20);
    check("sat_active4", 32'(run_active4), 32'd1);
    drive(1'b0, 1);
    check("sat_len4",   32'(len4),       32'd15);
    check("sat_sat4",   32'(len_sat4),   32'd1);
    check("sat_valid4", 32'(len_valid4), 32'd1);
    check("sat_len8",   32'(len8),       32'd20);
    check("sat_sat8",   32'(len_sat8),   32'd0);
    tick();

    // --- backpressure / overrun: runs of 2 then 4 with len_ready low
    do_reset();
    len_ready = 1'b0;
    drive(1'b1, 2);
    drive(1'b0, 1);
    check_both("ovr_first", 2, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4);
    check_both("ovr_held", 2, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1);
    check_both("ovr_drop", 2, 1'b1, 1'b0, 1'b0, 1'b1);
    len_ready = 1'b1;
    tick();
    check_both("ovr_accept", 2, 1'b0, 1'b0, 1'b0, 1'b1);

    // --- handshake and emit on the same edge
    do_reset();
    len_ready = 1'b0;
    drive(1'b1, 2);
    drive(1'b0, 1);
    check_both("simul_first", 2, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5);
    din       = 1'b0;
    len_ready = 1'b1;
    tick();
    check_both("simul_swap", 5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_both("simul_drain", 5, 1'b0, 1'b0, 1'b0, 1'b0);

    // --- asynchronous reset in mid-run with a result held in the slot
    do_reset();
    len_ready = 1'b0;
    drive(1'b1, 2);
    drive(1'b0, 1);
    drive(1'b1, 3);
    check_both("areset_pre", 2, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    m8  = model_reset();
    m4  = model_reset();
    #1;
    check_both("areset_now", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    din = 1'b0;
    tick();
    check_both("areset_after", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // --- randomized stimulus against the model
    len_ready = 1'b1;
    for (int c = 0; c < 600; c++) begin
      din       = ($urandom_range(0, 9) < 7);
      en        = ($urandom_range(0, 9) < 8);
      len_ready = ($urandom_range(0, 9) < 5);
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/run_length_monitor.md
# run_length_monitor

Downstream consumer of the single-bit output `o` of the lab sequence FSM (`es3`). The block measures the length, in sampled clock cycles, of every run of consecutive 1s on that bit. It presents each completed length on a one-deep registered output port with a valid/ready handshake. It also flags lengths that saturated the counter and results that were lost because the consumer stalled.

## Interface
- `W`, default 8: width of the run-length counter and of `len`; maximum reportable length is 2^W-1.

- `clk`  input  1  system clock, rising-edge active.
- `rst`  input  1  asynchronous, active-low reset. Low forces reset immediately; release is synchronous to `clk`.
- `din`  input  1  monitored bit (upstream FSM output `o`), sampled on rising `clk` when `en`=1.
- `en`  input  1  sample enable. When 0, counter and state hold; the output handshake keeps operating.
- `len`  output  W  length of the last completed run.
- `len_valid`  output  1  `len`/`len_sat` hold an unconsumed result.
- `len_ready`  input  1  consumer accepts the result on a rising edge where `len_valid`=1.
- `len_sat`  output  1  the run reported in `len` reached 2^W-1; the true length was ≥ 2^W-1.
- `run_active`  output  1  state is RUN (a run is being counted).
- `overrun`  output  1  sticky. Set when a completed run is discarded because the output slot was full; cleared only by reset.

## Operation
- The state machine has two states: IDLE and RUN. Internal counter `cnt` is W bits wide.
- Reset (`rst`=0) sets: state IDLE, `cnt`=0, `len`=0, `len_valid`=0, `len_sat`=0, `run_active`=0, `overrun`=0.
- IDLE, `en`=1, `din`=1: go to RUN, `cnt`=1.
- IDLE, `din`=0 or `en`=0: stay in IDLE, `cnt` unchanged.
- RUN, `en`=1, `din`=1: stay in RUN, `cnt` = `cnt`+1, saturating at 2^W-1. It never wraps to 0.
- RUN, `en`=1, `din`=0: the run ends. Go to IDLE and emit `cnt`.
- RUN, `en`=0: hold state and `cnt`. Cycles with `en`=0 are not counted.
- Output slot free means `len_valid`=0, or `len_valid`=1 and `len_ready`=1 on the same edge.
- Emit with slot free: `len` is loaded with `cnt`, `len_sat` with (`cnt`==2^W-1), and `len_valid` is set to 1.
- Emit with slot full: the result is dropped, `overrun` is set to 1, and `len`/`len_sat`/`len_valid` are unchanged.
- Handshake with no emit: `len_valid`=1 and `len_ready`=1 clears `len_valid`. `len` and `len_sat` keep their last values.
- Handshake and emit on the same edge: the new result is loaded and `len_valid` stays 1. This is not an overrun.
- `len_ready` while `len_valid`=0 has no effect.
- `len` and `len_sat` change only when a result is loaded. They stay stable while `len_valid`=1 and the result is not accepted.
- Reset asserted mid-run discards the partial run; no result is emitted.

## Timing
- All outputs are registered. No combinational path runs from any input to any output.
- Emit latency: `din`=0 sampled in RUN at edge N gives `len_valid`=1 and `len` updated immediately after edge N, visible for the cycle N→N+1.
- Minimum run: a single sampled 1 gives `len`=1.
- `run_active` rises after the edge that samples the first 1 and falls after the edge that samples the terminating 0.
- Back-to-back results: a new run may start on the edge after termination. The shortest pattern 1,0,1,0 produces one result every 2 sampled cycles. The consumer must accept within 2 cycles to avoid overrun.
- Throughput: one result per 2 cycles maximum, with `len_ready` held at 1.

## Test plan
- Reset: drive `rst`=0 mid-run with `din`=1 for 3 cycles → all outputs 0 immediately, without waiting for a clock edge. Release, then `din`=0 → `len_valid` stays 0.
- Basic run (W=8, `len_ready`=1): `din` = 0,1,1,1,0 → one pulse of `len_valid`=1 with `len`=3 and `len_sat`=0. `run_active` is high for 3 cycles.
- Enable gating: `din`=1 for 5 cycles with `en`=0 on cycles 2–3, then `din`=0 → `len`=3.
- Saturation (W=4): `din`=1 for 20 cycles, then 0 → `len`=15, `len_sat`=1, no wrap.
- Backpressure/overrun: `len_ready`=0. Apply runs of 2, then 4 → `len`=2 held, `len_valid`=1, `overrun`=1. Then raise `len_ready` → `len_valid` falls, `overrun` stays 1.
- Simultaneous: hold `len` (`len`=2) with `len_ready`=0. Raise `len_ready` on the same edge that a run of 5 terminates → `len`=5, `len_valid` stays 1, `overrun`=0.
